// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_e : sequencer state encoding (idle / fetching / halted)
//   Mem*Idle      : memory control pin levels whenever the sequencer is not fetching
//   HaltInstr     : instruction word that stops the sequencer when halt-on-zero is enabled
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHalt  = 2'd2
  } fetch_state_e;

  localparam logic MemCsIdle   = 1'b0;
  localparam logic MemReadIdle = 1'b0;
  localparam logic MemNoeIdle  = 1'b1;

  localparam logic [31:0] HaltInstr = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register.
//   clk, reset : clock and synchronous active-high reset (pc <= RESET_PC)
//   load       : load load_addr (branch redirect), highest priority after reset
//   inc        : advance pc by one, wrapping modulo 2^ADDR_W
//   pc         : current program counter
module fetch_pc_reg #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= ADDR_W'(RESET_PC);
    end else if (load) begin
      pc_q <= load_addr;
    end else if (inc) begin
      pc_q <= pc_q + ADDR_W'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer for an async-read instruction memory.
//   clk, reset          : clock, synchronous active-high reset
//   start, stop         : run control pulses
//   branch_take/_target : redirect pc (flushes the instruction register)
//   mem_data            : memory read data for mem_addr (combinational)
//   mem_addr/cs/read/noe: memory address and control pins
//   instr, instr_pc     : captured instruction and its fetch address
//   instr_valid/ready   : handshake towards decode
//   halted              : sequencer stopped on a zero word
module instr_fetch_ctrl
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W       = 7,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RESET_PC     = 0,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              branch_take,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_read,
  output logic              mem_noe,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              valid_q, valid_d;
  logic              mem_cs_q, mem_read_q, mem_noe_q, halted_q;
  logic [ADDR_W-1:0] pc;
  logic              pc_load, pc_inc, capture;
  logic              slot_free, zero_word;

  fetch_pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_addr(branch_target),
    .pc       (pc)
  );

  assign slot_free = !valid_q || instr_ready;
  assign zero_word = HALT_ON_ZERO && (mem_data == DATA_W'(HaltInstr));

  always_comb begin
    state_d = state_q;
    // Acceptance without a new capture empties the slot.
    valid_d = valid_q && !instr_ready;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (branch_take) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
        end else if (start && !stop) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (branch_take) begin
          // Branch beats capture and halt; first target word lands next edge.
          pc_load = 1'b1;
          valid_d = 1'b0;
          if (stop) state_d = StIdle;
        end else if (stop) begin
          state_d = StIdle;
        end else if (slot_free) begin
          if (zero_word) begin
            state_d = StHalt;
          end else begin
            capture = 1'b1;
            pc_inc  = 1'b1;
            valid_d = 1'b1;
          end
        end
      end
      StHalt: begin
        if (branch_take) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin levels are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      mem_cs_q   <= MemCsIdle;
      mem_read_q <= MemReadIdle;
      mem_noe_q  <= MemNoeIdle;
      halted_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (capture) begin
        instr_q    <= mem_data;
        instr_pc_q <= pc;
      end
      if (state_d == StFetch) begin
        mem_cs_q   <= 1'b1;
        mem_read_q <= 1'b1;
        mem_noe_q  <= 1'b0;
      end else begin
        mem_cs_q   <= MemCsIdle;
        mem_read_q <= MemReadIdle;
        mem_noe_q  <= MemNoeIdle;
      end
      halted_q <= (state_d == StHalt);
    end
  end

  assign mem_addr    = pc;
  assign mem_cs      = mem_cs_q;
  assign mem_read    = mem_read_q;
  assign mem_noe     = mem_noe_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Sequencer for the 128 x 32 instruction memory (async read, active-low output enable, chip select, read strobe).
- Owns the program counter.
- Drives the memory control and address pins.
- Captures each fetched word into a one-entry instruction register.
- Presents that register to the decode stage with a valid/ready handshake.
- Handles start/stop, branch redirect and halt-on-zero-word.

Parameters:
ADDR_W, 7, instruction-memory word-address width.
DATA_W, 32, instruction width.
RESET_PC, 0, PC value after reset.
HALT_ON_ZERO, 1, when 1, fetching the all-zero word halts the sequencer.

Ports:
clk  in  1  system clock, all state updates on rising edge.
reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
start  in  1  pulse; IDLE -> FETCH.
stop  in  1  pulse; any fetching state -> IDLE.
branch_take  in  1  pulse; redirect PC to branch_target.
branch_target  in  ADDR_W  redirect address.
mem_data  in  DATA_W  instruction-memory data bus (combinational read of mem_addr).
mem_addr  out  ADDR_W  memory address, equals pc register.
mem_cs  out  1  memory chip select.
mem_read  out  1  memory read strobe.
mem_noe  out  1  memory output enable, active low.
instr  out  DATA_W  captured instruction.
instr_pc  out  ADDR_W  address instr was fetched from.
instr_valid  out  1  instr holds an unconsumed word.
instr_ready  in  1  consumer accepts instr this cycle when instr_valid=1.
halted  out  1  sequencer in HALT.

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, instr=0, instr_pc=0, instr_valid=0, halted=0.
  - Memory pins idle: mem_cs=0, mem_read=0, mem_noe=1.
  - mem_addr=pc is always driven.
- Reset mid-operation discards the pending word and any branch asserted in the same cycle.
- States: IDLE, FETCH, HALT.
  - mem_cs=1, mem_read=1, mem_noe=0 only in FETCH (decoded from state, no extra cycle).
  - halted=1 only in HALT.
- Slot free: (instr_valid=0) or (instr_ready=1).
  - A consumer acceptance with no new capture clears instr_valid at the edge.
- FETCH, slot free, no branch/stop, word nonzero or HALT_ON_ZERO=0:
  - instr<=mem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
  - Fetch latency: word at address A is visible on instr one edge after pc=A.
  - Sustained throughput: one word per cycle while instr_ready=1.
- FETCH, slot not free: hold pc, instr and instr_valid; memory stays enabled.
- PC arithmetic: modulo 2^ADDR_W; 127+1 wraps to 0 with no flag.
- Halt-on-zero: in FETCH with slot free, HALT_ON_ZERO=1 and mem_data==0:
  - Zero word is not captured; pc is not incremented.
  - instr_valid<=0 only if the slot was freed by acceptance, else unchanged.
  - state<=HALT.
- Branch (any state):
  - pc<=branch_target and instr_valid<=0 (flush).
  - Wins over capture and halt-on-zero in the same cycle.
  - In FETCH: remains in FETCH, first target word captured on the following edge.
  - In IDLE: pc loaded only.
  - In HALT: pc loaded, state<=FETCH (the only exit from HALT besides reset).
- start: IDLE -> FETCH; ignored in FETCH and HALT.
- stop:
  - FETCH -> IDLE with no capture that edge; instr/instr_valid kept until consumed.
  - Ignored in HALT.
  - Wins over start if both are asserted.
- Branch + stop in FETCH: pc loaded, flush, state<=IDLE.
- instr_ready while instr_valid=0: ignored.

Decomposition:
- Shared package instr_fetch_pkg holds:
  - state encoding (IDLE/FETCH/HALT as 2-bit enum constants);
  - memory idle pin levels (cs=0, read=0, noe=1);
  - the zero-instruction halt constant.
- One natural sub-module, fetch_pc_reg: PC register with load (branch), increment and hold priority, parameterised by ADDR_W and RESET_PC.
- FSM and instruction register stay in the top level.

Test Plan:
Bench memory image: word0=32'hB8800000, word1=32'hB8801001, words 2..9 = 8 down to 1, word10=0.
1. Reset, start, instr_ready=1 held -> instr sequence B8800000 (pc0), B8801001 (pc1), 8, 7, ... 1 on consecutive cycles. Then halted=1 with instr_pc=9, pc=10, memory pins back to idle.
2. Start, instr_ready=0 for 3 cycles after the first capture -> instr=B8800000, instr_valid=1 and pc=1 stable throughout; on instr_ready=1, the next edge shows B8801001.
3. In FETCH at pc=4, pulse branch_take with target=1 -> instr_valid=0 next edge; following edge instr=B8801001, instr_pc=1.
4. In HALT, pulse branch_take with target=0 -> FETCH; instr=B8800000, halted=0. Pulse start alone in HALT -> no change.
5. start and stop in the same cycle from IDLE -> stays IDLE. stop during FETCH at pc=3 -> IDLE, pc=3, last captured word held until instr_ready.
6. Assert reset mid-fetch at pc=6 with branch_take=1 -> next edge pc=0, IDLE, instr_valid=0, mem_noe=1.
